// File: rtl/message_tx_controller_pkg.sv
// Shared definitions for the outgoing-message controller: FSM state encoding,
// ASCII codes, buffer geometry, timeout sizing and the slot position helper.
package message_tx_controller_pkg;

   localparam int MSG_CHARS      = 16;
   localparam int MSG_W          = 8 * MSG_CHARS;
   localparam int COUNT_W        = 5;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0]         DEL_CODE   = 8'd127;
   localparam logic [7:0]         FILL_CODE  = 8'd32;
   localparam logic [COUNT_W-1:0] COUNT_FULL = 5'd16;
   localparam logic [COUNT_W-1:0] COUNT_ZERO = 5'd0;
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_EDIT      = 2'd0,
      ST_ARM       = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_CLEAR     = 2'd3
   } state_e;

   // Char k lives at [127-8k -: 8], i.e. its LSB is at 8*(15-k); for a 4-bit
   // slot index 15-k is simply the bitwise inverse of k.
   function automatic logic [6:0] slot_lsb(input logic [3:0] k);
      return {~k, 3'b000};
   endfunction

endpackage

// File: rtl/message_tx_controller_char_buffer.sv
// Sixteen-slot ASCII message buffer: appends at the fill point, deletes the last
// character, bulk-clears to spaces, and reports count / full / empty.
module message_tx_controller_char_buffer
   import message_tx_controller_pkg::*;
(
   input  logic               clock,
   input  logic               RESETN,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   input  logic               del_en,
   input  logic               clr_en,
   output logic [MSG_W-1:0]   slots,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty
);

   logic [MSG_W-1:0]   slots_r;
   logic [COUNT_W-1:0] count_r;
   logic [3:0]         wr_idx_s;
   logic [3:0]         del_idx_s;

   assign wr_idx_s  = count_r[3:0];
   assign del_idx_s = count_r[3:0] - 4'd1;

   assign slots = slots_r;
   assign count = count_r;
   assign full  = (count_r == COUNT_FULL);
   assign empty = (count_r == COUNT_ZERO);

   // Slot storage and fill count; clear has priority, writes/deletes are guarded by full/empty.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         slots_r <= {MSG_CHARS{FILL_CODE}};
         count_r <= COUNT_ZERO;
      end else if (clr_en) begin
         slots_r <= {MSG_CHARS{FILL_CODE}};
         count_r <= COUNT_ZERO;
      end else if (wr_en && !full) begin
         slots_r[slot_lsb(wr_idx_s) +: 8] <= wr_data;
         count_r <= count_r + 5'd1;
      end else if (del_en && !empty) begin
         slots_r[slot_lsb(del_idx_s) +: 8] <= FILL_CODE;
         count_r <= count_r - 5'd1;
      end else begin
         slots_r <= slots_r;
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/message_tx_controller.sv
// Outgoing-message controller: edits the message buffer from the ASCII path,
// then runs the data_ready/done handshake with gpio_protocol, with a timeout
// that aborts back to editing while keeping the buffer for a retry.
module message_tx_controller
   import message_tx_controller_pkg::*;
(
   input  logic               clock,
   input  logic               RESETN,
   input  logic               char_valid,
   input  logic [7:0]         char_in,
   input  logic               send_req,
   input  logic               tx_done,
   output logic               tx_data_ready,
   output logic [MSG_W-1:0]   message_out,
   output logic [COUNT_W-1:0] char_count,
   output logic               busy,
   output logic               char_drop,
   output logic               tx_error
);

   state_e             state_r, state_nxt_s;
   logic [TO_W-1:0]    to_cnt_r, to_cnt_nxt_s;
   logic               tx_data_ready_r, tdr_nxt_s;
   logic               char_drop_r, drop_nxt_s;
   logic               tx_error_r, err_nxt_s;
   logic               busy_r;

   logic               buf_wr_s, buf_del_s, buf_clr_s;
   logic               buf_full_s, buf_empty_s;
   logic [COUNT_W-1:0] buf_count_s;

   logic               is_del_s, wr_ok_s, del_ok_s, send_go_s;
   logic [COUNT_W-1:0] count_after_s;

   message_tx_controller_char_buffer u_buffer (
      .clock   (clock),
      .RESETN  (RESETN),
      .wr_en   (buf_wr_s),
      .wr_data (char_in),
      .del_en  (buf_del_s),
      .clr_en  (buf_clr_s),
      .slots   (message_out),
      .count   (buf_count_s),
      .full    (buf_full_s),
      .empty   (buf_empty_s)
   );

   assign char_count    = buf_count_s;
   assign tx_data_ready = tx_data_ready_r;
   assign char_drop     = char_drop_r;
   assign tx_error      = tx_error_r;
   assign busy          = busy_r;

   // Classify the incoming char and predict the count it leaves, so a same-cycle send sees it.
   always_comb begin
      is_del_s = (char_in == DEL_CODE);
      wr_ok_s  = char_valid && !is_del_s && !buf_full_s;
      del_ok_s = char_valid && is_del_s && !buf_empty_s;
      if (wr_ok_s) begin
         count_after_s = buf_count_s + 5'd1;
      end else if (del_ok_s) begin
         count_after_s = buf_count_s - 5'd1;
      end else begin
         count_after_s = buf_count_s;
      end
      send_go_s = send_req && (count_after_s != COUNT_ZERO);
   end

   // State, timeout counter and all registered 1-bit outputs.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         state_r         <= ST_EDIT;
         to_cnt_r        <= '0;
         tx_data_ready_r <= 1'b0;
         char_drop_r     <= 1'b0;
         tx_error_r      <= 1'b0;
         busy_r          <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         to_cnt_r        <= to_cnt_nxt_s;
         tx_data_ready_r <= tdr_nxt_s;
         char_drop_r     <= drop_nxt_s;
         tx_error_r      <= err_nxt_s;
         busy_r          <= (state_nxt_s != ST_EDIT);
      end
   end

   // Next-state selection; tx_done is tested before the timeout so it wins a tie.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EDIT: begin
            if (send_go_s) begin
               state_nxt_s = ST_ARM;
            end else begin
               state_nxt_s = ST_EDIT;
            end
         end
         ST_ARM: begin
            state_nxt_s = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               state_nxt_s = ST_CLEAR;
            end else if (to_cnt_r == TO_LAST) begin
               state_nxt_s = ST_EDIT;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         ST_CLEAR: begin
            if (!tx_done) begin
               state_nxt_s = ST_EDIT;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default: begin
            state_nxt_s = ST_EDIT;
         end
      endcase
   end

   // Per-state buffer commands and next values of the registered outputs and timeout counter.
   always_comb begin
      buf_wr_s     = 1'b0;
      buf_del_s    = 1'b0;
      buf_clr_s    = 1'b0;
      drop_nxt_s   = 1'b0;
      err_nxt_s    = 1'b0;
      tdr_nxt_s    = 1'b0;
      to_cnt_nxt_s = to_cnt_r;
      case (state_r)
         ST_EDIT: begin
            buf_wr_s   = wr_ok_s;
            buf_del_s  = del_ok_s;
            drop_nxt_s = char_valid && !is_del_s && buf_full_s;
         end
         ST_ARM: begin
            tdr_nxt_s    = 1'b1;
            to_cnt_nxt_s = '0;
            drop_nxt_s   = char_valid;
         end
         ST_WAIT_DONE: begin
            drop_nxt_s = char_valid;
            if (tx_done) begin
               tdr_nxt_s = 1'b0;
            end else if (to_cnt_r == TO_LAST) begin
               tdr_nxt_s = 1'b0;
               err_nxt_s = 1'b1;
            end else begin
               tdr_nxt_s    = 1'b1;
               to_cnt_nxt_s = to_cnt_r + TO_W'(1);
            end
         end
         ST_CLEAR: begin
            buf_clr_s  = 1'b1;
            drop_nxt_s = char_valid;
         end
         default: begin
            buf_clr_s = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_message_tx_controller.sv
// Directed and randomized bench for message_tx_controller; expectations come
// from a queue-of-characters model of the message and the handshake timing rules.
module tb_message_tx_controller;

   logic         clock      = 1'b0;
   logic         RESETN     = 1'b0;
   logic         char_valid = 1'b0;
   logic [7:0]   char_in    = 8'h00;
   logic         send_req   = 1'b0;
   logic         tx_done    = 1'b0;
   logic         tx_data_ready;
   logic [127:0] message_out;
   logic [4:0]   char_count;
   logic         busy;
   logic         char_drop;
   logic         tx_error;

   int checks = 0;
   int errors = 0;

   logic [7:0]   model_q[$];
   logic [127:0] all_sp;

   message_tx_controller dut (
      .clock         (clock),
      .RESETN        (RESETN),
      .char_valid    (char_valid),
      .char_in       (char_in),
      .send_req      (send_req),
      .tx_done       (tx_done),
      .tx_data_ready (tx_data_ready),
      .message_out   (message_out),
      .char_count    (char_count),
      .busy          (busy),
      .char_drop     (char_drop),
      .tx_error      (tx_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_msg();
      logic [127:0] m;
      m = '0;
      for (int k = 0; k < 16; k++) begin
         m[127 - 8*k -: 8] = (k < model_q.size()) ? model_q[k] : 8'h20;
      end
      return m;
   endfunction

   function automatic logic [7:0] rand_char();
      if ($urandom_range(0, 4) == 0) return 8'd127;
      return 8'($urandom_range(33, 126));
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One EDIT-state char strobe (optionally with send_req), model updated and checked.
   task automatic type_char(input logic [7:0] c, input bit with_send);
      logic exp_drop;
      exp_drop   = 1'b0;
      char_valid = 1'b1;
      char_in    = c;
      send_req   = with_send;
      if (c == 8'd127) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
      end else if (model_q.size() < 16) begin
         model_q.push_back(c);
      end else begin
         exp_drop = 1'b1;
      end
      tick();
      char_valid = 1'b0;
      send_req   = 1'b0;
      check("char_drop", 128'(char_drop), 128'(exp_drop));
      check("char_count", 128'(char_count), 128'(model_q.size()));
      check("message", message_out, model_msg());
   endtask

   // Starts right after the edge that entered ARM; walks the handshake to completion.
   task automatic finish_send(input int hold, input int extra_done);
      logic [127:0] snap;
      logic         exp_drop;
      snap = model_msg();
      check("arm_tdr_low", 128'(tx_data_ready), 128'(1'b0));
      check("arm_busy", 128'(busy), 128'(1'b1));
      tick();
      check("tdr_rise", 128'(tx_data_ready), 128'(1'b1));
      check("tx_msg", message_out, snap);
      for (int i = 0; i < hold; i++) begin
         exp_drop   = 1'($urandom_range(0, 1));
         char_valid = exp_drop;
         char_in    = rand_char();
         tick();
         char_valid = 1'b0;
         check("busy_drop", 128'(char_drop), 128'(exp_drop));
         check("busy_msg", message_out, snap);
         check("tdr_held", 128'(tx_data_ready), 128'(1'b1));
      end
      tx_done = 1'b1;
      tick();
      check("done_tdr_low", 128'(tx_data_ready), 128'(1'b0));
      check("done_msg", message_out, snap);
      for (int i = 0; i < extra_done; i++) begin
         tick();
         check("clear_busy", 128'(busy), 128'(1'b1));
      end
      tx_done = 1'b0;
      tick();
      model_q.delete();
      check("clear_count", 128'(char_count), 128'(0));
      check("clear_msg", message_out, all_sp);
      check("clear_idle", 128'(busy), 128'(1'b0));
   endtask

   initial begin
      int n;
      all_sp = {16{8'h20}};

      // Reset state
      #12;
      check("rst_msg", message_out, all_sp);
      check("rst_count", 128'(char_count), 128'(0));
      check("rst_tdr", 128'(tx_data_ready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_pulses", 128'({char_drop, tx_error}), 128'(0));
      @(negedge clock);
      RESETN = 1'b1;
      tick();

      // "hi" then send
      type_char(8'h68, 1'b0);
      type_char(8'h69, 1'b0);
      check("hi_msg", message_out, {16'h6869, {14{8'h20}}});
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      finish_send(3, 0);

      // 17 x 'a': last one dropped
      for (int i = 0; i < 17; i++) type_char(8'h61, 1'b0);
      check("full_msg", message_out, {16{8'h61}});
      check("full_count", 128'(char_count), 128'(16));
      for (int i = 0; i < 16; i++) type_char(8'd127, 1'b0);

      // a, b, DEL x3, then send on empty buffer is ignored
      type_char(8'h61, 1'b0);
      type_char(8'h62, 1'b0);
      for (int i = 0; i < 3; i++) type_char(8'd127, 1'b0);
      check("empty_msg", message_out, all_sp);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      check("empty_send_busy", 128'(busy), 128'(0));
      tick();
      check("empty_send_tdr", 128'(tx_data_ready), 128'(0));

      // tx_done while editing is ignored; same-cycle char+send includes the char
      tx_done = 1'b1;
      type_char(8'h70, 1'b0);
      check("edit_done_idle", 128'(busy), 128'(0));
      tx_done = 1'b0;
      type_char(8'h71, 1'b1);
      finish_send(2, 2);

      // DEL emptying the buffer in the send cycle cancels the request
      type_char(8'h72, 1'b0);
      type_char(8'd127, 1'b1);
      check("del_send_busy", 128'(busy), 128'(0));
      tick();
      check("del_send_tdr", 128'(tx_data_ready), 128'(0));

      // Timeout: 64 cycles in WAIT_DONE without tx_done
      type_char(8'h78, 1'b0);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      tick();
      n = 0;
      while (n < 100 && tx_error !== 1'b1) begin
         tick();
         n++;
      end
      check("timeout_cycles", 128'(n), 128'(64));
      check("timeout_tdr", 128'(tx_data_ready), 128'(0));
      check("timeout_idle", 128'(busy), 128'(0));
      check("timeout_msg", message_out, model_msg());
      check("timeout_count", 128'(char_count), 128'(1));
      tick();
      check("err_one_cycle", 128'(tx_error), 128'(0));

      // Retry where tx_done lands on the timeout cycle: done wins
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      tick();
      for (int i = 0; i < 63; i++) tick();
      tx_done = 1'b1;
      tick();
      check("tie_no_err", 128'(tx_error), 128'(0));
      check("tie_tdr", 128'(tx_data_ready), 128'(0));
      check("tie_busy", 128'(busy), 128'(1));
      tx_done = 1'b0;
      tick();
      model_q.delete();
      check("tie_count", 128'(char_count), 128'(0));
      check("tie_msg", message_out, all_sp);

      // Randomized edit/send rounds
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) type_char(rand_char(), 1'b0);
         if (model_q.size() > 0) begin
            send_req = 1'b1;
            tick();
            send_req = 1'b0;
            finish_send($urandom_range(0, 40), $urandom_range(0, 3));
         end
      end

      // Reset in the middle of WAIT_DONE
      type_char(8'h6b, 1'b0);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      tick();
      char_valid = 1'b1;
      char_in    = 8'h6d;
      tick();
      char_valid = 1'b0;
      check("wait_drop", 128'(char_drop), 128'(1));
      check("wait_msg", message_out, model_msg());
      #2;
      RESETN = 1'b0;
      #1;
      model_q.delete();
      check("async_tdr", 128'(tx_data_ready), 128'(0));
      check("async_msg", message_out, all_sp);
      check("async_count", 128'(char_count), 128'(0));
      check("async_busy", 128'(busy), 128'(0));
      @(negedge clock);
      RESETN = 1'b1;
      tick();
      type_char(8'h7a, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
